// File: rtl/rtype_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rtype_sequencer_if : instruction-fetch, decode-field and strobe bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface rtype_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_control;
    logic        alu_en;
    logic        regwrite_en;
    logic        halt;
    logic        halted;
    logic        trap;
    logic [31:0] pc;

    modport master (
        output imem_req, imem_addr, rs1_addr, rs2_addr, rd_addr,
               alu_control, alu_en, regwrite_en, halted, trap, pc,
        input  imem_valid, imem_instr, halt
    );

    modport slave (
        input  imem_req, imem_addr, rs1_addr, rs2_addr, rd_addr,
               alu_control, alu_en, regwrite_en, halted, trap, pc,
        output imem_valid, imem_instr, halt
    );
endinterface
`default_nettype wire

// File: rtl/rtype_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rtype_sequencer : multi-cycle fetch/decode/execute/writeback controller
//                   for the R-type ALU datapath, with PC and illegal trap
// Rev 1.0
// ---------------------------------------------------------------------------
module rtype_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MUL_CYCLES = 4
) (
    input wire                clk,
    input wire                reset_n,
    rtype_sequencer_if.master bus
);

    localparam logic [2:0] c_FETCH     = 3'd0;
    localparam logic [2:0] c_DECODE    = 3'd1;
    localparam logic [2:0] c_EXECUTE   = 3'd2;
    localparam logic [2:0] c_WRITEBACK = 3'd3;
    localparam logic [2:0] c_HALTED    = 3'd4;
    localparam logic [2:0] c_TRAP      = 3'd5;

    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_F7_ZERO   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;
    localparam logic [3:0] c_MUL_LOAD  = 4'(MUL_CYCLES - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [3:0]  r_alu_control;
    logic [3:0]  r_count;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic        w_accept;
    logic        w_dec_legal;
    logic        w_dec_mul;
    logic [3:0]  w_dec_code;

    logic        w_imem_req;
    logic        w_alu_en;
    logic        w_regwrite_en;
    logic        w_halted;
    logic        w_trap;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];
    assign w_rd     = r_ir[11:7];
    assign w_accept = (r_state == c_FETCH) && bus.imem_valid;

    always_comb begin
        w_dec_legal = 1'b0;
        w_dec_mul   = 1'b0;
        w_dec_code  = 4'b0000;
        if (w_opcode == c_OP_RTYPE) begin
            if (w_funct3 == 3'd0) begin
                if (w_funct7 == c_F7_ZERO) begin
                    w_dec_legal = 1'b1;
                    w_dec_code  = 4'b0010;
                end else if (w_funct7 == c_F7_ALT) begin
                    w_dec_legal = 1'b1;
                    w_dec_code  = 4'b0100;
                end
            end else if ((w_funct3 != 3'd3) && (w_funct7 == c_F7_ZERO)) begin
                w_dec_legal = 1'b1;
                case (w_funct3)
                    3'd1:    w_dec_code = 4'b0011;
                    3'd2: begin
                        w_dec_code = 4'b0110;
                        w_dec_mul  = 1'b1;
                    end
                    3'd4:    w_dec_code = 4'b0111;
                    3'd5:    w_dec_code = 4'b0101;
                    3'd6:    w_dec_code = 4'b0001;
                    default: w_dec_code = 4'b0000;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_FETCH:     if (w_accept) w_next_state = c_DECODE;
            c_DECODE:    w_next_state = w_dec_legal ? c_EXECUTE : c_TRAP;
            c_EXECUTE:   if (r_count == 4'd0) w_next_state = c_WRITEBACK;
            c_WRITEBACK: w_next_state = bus.halt ? c_HALTED : c_FETCH;
            c_HALTED:    if (!bus.halt) w_next_state = c_FETCH;
            c_TRAP:      w_next_state = c_TRAP;
            default:     w_next_state = c_FETCH;
        endcase
    end

    // Decode outputs are captured here so alu_control holds until the next DECODE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_ir          <= 32'h0000_0000;
            r_alu_control <= 4'b0000;
            r_count       <= 4'd0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (w_accept) r_ir <= bus.imem_instr;
                end
                c_DECODE: begin
                    if (w_dec_legal) begin
                        r_alu_control <= w_dec_code;
                        r_count       <= w_dec_mul ? c_MUL_LOAD : 4'd0;
                    end
                end
                c_EXECUTE: begin
                    if (r_count != 4'd0) r_count <= r_count - 4'd1;
                end
                c_WRITEBACK: begin
                    r_pc <= r_pc + 32'd4;
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes decode straight from state so a reset drops them asynchronously
    always_comb begin
        w_imem_req    = 1'b0;
        w_alu_en      = 1'b0;
        w_regwrite_en = 1'b0;
        w_halted      = 1'b0;
        w_trap        = 1'b0;
        case (r_state)
            c_FETCH:     w_imem_req    = 1'b1;
            c_EXECUTE:   w_alu_en      = 1'b1;
            c_WRITEBACK: w_regwrite_en = (w_rd != 5'd0);
            c_HALTED:    w_halted      = 1'b1;
            c_TRAP:      w_trap        = 1'b1;
            default: begin
            end
        endcase
    end

    assign bus.imem_req    = w_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.pc          = r_pc;
    assign bus.rs1_addr    = r_ir[19:15];
    assign bus.rs2_addr    = r_ir[24:20];
    assign bus.rd_addr     = w_rd;
    assign bus.alu_control = r_alu_control;
    assign bus.alu_en      = w_alu_en;
    assign bus.regwrite_en = w_regwrite_en;
    assign bus.halted      = w_halted;
    assign bus.trap        = w_trap;

endmodule
`default_nettype wire
